// File: rtl/cpu_pkg.sv
// cpu_pkg: shared multicycle-CPU types and constants used by the mult/div unit.
//   MD_OP_MULT / MD_OP_DIV : op encoding on the mult_div op port
//   md_state_t             : mult_div sequencer states
//   MD_WIDTH / MD_CNT_W    : default datapath width and matching iteration-counter width
package cpu_pkg;
  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH) + 1;
  localparam logic MD_OP_MULT = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;
  typedef enum logic [1:0] {MD_IDLE, MD_MULT, MD_DIV, MD_FIN} md_state_t;
endpackage

// File: rtl/md_div_step.sv
// md_div_step: one combinational restoring-division step on unsigned magnitudes.
//   rem_in   in  partial remainder
//   quo_in   in  dividend bits still to shift in, with quotient bits collecting at the bottom
//   divisor  in  divisor magnitude
//   rem_out  out next partial remainder
//   quo_out  out quo_in shifted left with the new quotient bit appended
module md_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);
  logic [WIDTH:0] shifted;
  logic [WIDTH+1:0] diff;
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff = {1'b0, shifted} - {2'b00, divisor};
    // A borrow (negative trial difference) means the divisor did not fit: restore.
    rem_out = diff[WIDTH+1] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], ~diff[WIDTH+1]};
  end
endmodule

// File: rtl/mult_div.sv
// mult_div: iterative multiply (radix-2 Booth) / divide (restoring) unit producing HI/LO.
//   clk, reset   clock and asynchronous active-high reset
//   start        one-cycle request, sampled only while idle
//   op           0 = MULT, 1 = DIV
//   op_unsigned  only with MULT_DIV_UNSIGNED_EN defined: 1 = MULTU/DIVU
//   a, b         multiplicand/dividend and multiplier/divisor
//   busy         operation in progress
//   done         one-cycle completion pulse, hi/lo valid with it
//   div_zero     last accepted DIV had b == 0
//   hi, lo       MULT: upper/lower product; DIV: remainder/quotient
module mult_div
  import cpu_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
`ifdef MULT_DIV_UNSIGNED_EN
  input  logic             op_unsigned,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  md_state_t state;
  logic op_r, sgn_r, sgn_in;
  logic [WIDTH-1:0] a_r, b_r, rem, quo, rem_nx, quo_nx;
  logic [WIDTH-1:0] b_mag, a_mag_in, mul_hi, div_hi, div_lo;
  logic [2*WIDTH:0] prod;
  logic [WIDTH:0] a_ext, acc_ext, booth_sum;
  logic [CNT_W-1:0] cnt;
`ifdef MULT_DIV_UNSIGNED_EN
  assign sgn_in = ~op_unsigned;
`else
  assign sgn_in = 1'b1;
`endif
  // Booth accumulator is worked one bit wider so that adding/subtracting the
  // most negative (or a large unsigned) multiplicand cannot overflow; the
  // subsequent shift brings the result back into WIDTH bits.
  always_comb begin
    a_ext = {sgn_r & a_r[WIDTH-1], a_r};
    acc_ext = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
    booth_sum = (prod[1:0] == 2'b01) ? acc_ext + a_ext :
                (prod[1:0] == 2'b10) ? acc_ext - a_ext : acc_ext;
    b_mag = (sgn_r & b_r[WIDTH-1]) ? -b_r : b_r;
    a_mag_in = (sgn_in & a[WIDTH-1]) ? -a : a;
    // Booth treats b as signed; an unsigned b with its MSB set is worth 2^WIDTH more,
    // which only adds a to the upper half.
    mul_hi = prod[2*WIDTH:WIDTH+1] + ((!sgn_r && b_r[WIDTH-1]) ? a_r : '0);
    div_lo = (sgn_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1])) ? -quo : quo;
    div_hi = (sgn_r & a_r[WIDTH-1]) ? -rem : rem;
  end
  md_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (rem),
    .quo_in (quo),
    .divisor(b_mag),
    .rem_out(rem_nx),
    .quo_out(quo_nx)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MD_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      div_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      op_r <= 1'b0;
      sgn_r <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      rem <= '0;
      quo <= '0;
      prod <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: if (start) begin
          a_r <= a;
          b_r <= b;
          op_r <= op;
          sgn_r <= sgn_in;
          busy <= 1'b1;
          div_zero <= 1'b0;
          cnt <= CNT_W'(WIDTH);
          prod <= {{WIDTH{1'b0}}, b, 1'b0};
          rem <= '0;
          quo <= a_mag_in;
          state <= (op == MD_OP_MULT) ? MD_MULT : (b == '0) ? MD_FIN : MD_DIV;
        end
        MD_MULT: begin
          prod <= {booth_sum, prod[WIDTH:1]};
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= MD_FIN;
        end
        MD_DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= MD_FIN;
        end
        MD_FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
          state <= MD_IDLE;
          // A divide by zero leaves hi/lo untouched and only raises the flag.
          if (op_r == MD_OP_DIV && b_r == '0) div_zero <= 1'b1;
          else if (op_r == MD_OP_DIV) {hi, lo} <= {div_hi, div_lo};
          else {hi, lo} <= {mul_hi, prod[WIDTH:1]};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: self-checking bench for mult_div with an arithmetic reference model.
module tb_mult_div;
  logic clk = 1'b0;
  logic reset, start, op, op_uns;
  logic [31:0] a_i, b_i;
  logic busy, done, div_zero;
  logic [31:0] hi, lo;
  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  logic e_busy, e_done, e_dz, p_dz;
  logic [31:0] e_hi, e_lo;
  logic [63:0] p_res;
  int left;

  always #5 clk = ~clk;

  mult_div #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
`ifdef MULT_DIV_UNSIGNED_EN
    .op_unsigned(op_uns),
`endif
    .a       (a_i),
    .b       (b_i),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  function automatic logic [63:0] ref_res(input logic o, input logic u, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    sx = u ? longint'({32'd0, x}) : longint'($signed(x));
    sy = u ? longint'({32'd0, y}) : longint'($signed(y));
    if (!o) return sx * sy;
    if (sy == 0) return '0;
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted start produces its result WIDTH+1 edges later
  // (1 edge for a divide by zero); starts are ignored until then.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_busy <= 1'b0;
      e_done <= 1'b0;
      e_dz <= 1'b0;
      e_hi <= '0;
      e_lo <= '0;
      left <= 0;
    end else begin
      e_done <= 1'b0;
      if (left != 0) begin
        left <= left - 1;
        if (left == 1) begin
          e_done <= 1'b1;
          e_busy <= 1'b0;
          if (p_dz) e_dz <= 1'b1;
          else {e_hi, e_lo} <= p_res;
        end
      end else if (start) begin
        e_busy <= 1'b1;
        e_dz <= 1'b0;
        p_dz <= op && (b_i == 32'd0);
        p_res <= ref_res(op, op_uns, a_i, b_i);
        left <= (op && b_i == 32'd0) ? 1 : 33;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("div_zero", 32'(div_zero), 32'(e_dz));
    chk("hi", hi, e_hi);
    chk("lo", lo, e_lo);
  end

  task automatic start_op(input logic o, input logic u, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op = o;
    op_uns = u;
    a_i = x;
    b_i = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 60 && !done) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done within %0d cycles, required done", n);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op = 1'b0;
    op_uns = 1'b0;
    a_i = '0;
    b_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_dz", 32'(div_zero), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    start_op(1'b0, 1'b0, 32'd7, -32'sd3);
    wait_done(lat);
    chk("t1_lat", 32'(lat), 32'd34);
    chk("t1_hi", hi, 32'hFFFFFFFF);
    chk("t1_lo", lo, 32'hFFFFFFEB);
    @(negedge clk);
    start_op(1'b1, 1'b0, -32'sd7, 32'd2);
    wait_done(lat);
    chk("t2_lat", 32'(lat), 32'd34);
    chk("t2_lo", lo, 32'hFFFFFFFD);
    chk("t2_hi", hi, 32'hFFFFFFFF);
    chk("t2_dz", 32'(div_zero), 32'h0);
    @(negedge clk);
    start_op(1'b1, 1'b0, 32'd5, 32'd0);
    wait_done(lat);
    chk("t3_lat", 32'(lat), 32'd2);
    chk("t3_dz", 32'(div_zero), 32'h1);
    chk("t3_hi", hi, 32'hFFFFFFFF);
    chk("t3_lo", lo, 32'hFFFFFFFD);
    @(negedge clk);
    start_op(1'b0, 1'b0, 32'h80000000, 32'h80000000);
    @(negedge clk);
    chk("t3_dz_clr", 32'(div_zero), 32'h0);
    wait_done(lat);
    chk("t4_mhi", hi, 32'h40000000);
    chk("t4_mlo", lo, 32'h0);
    @(negedge clk);
    start_op(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat);
    chk("t4_dlo", lo, 32'h80000000);
    chk("t4_dhi", hi, 32'h0);
    @(negedge clk);
    start_op(1'b1, 1'b0, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("t5_hi", hi, 32'h0);
    chk("t5_lo", lo, 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) chk("t5_no_done", 32'(done), 32'h0);
    end
    start_op(1'b0, 1'b0, 32'd3, 32'd4);
    wait_done(lat);
    chk("t5_lo12", lo, 32'd12);
    chk("t5_hi0", hi, 32'h0);
    @(negedge clk);
    start_op(1'b0, 1'b0, 32'd1234, 32'd5678);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op = 1'b1;
    a_i = 32'd9;
    b_i = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    chk("t6_lo", lo, 32'h006AE9BC);
    chk("t6_hi", hi, 32'h0);
    start_op(1'b1, 1'b0, 32'd100, 32'd7);
    wait_done(lat);
    chk("t6_b2b_lat", 32'(lat), 32'd34);
    chk("t6_b2b_lo", lo, 32'd14);
    chk("t6_b2b_hi", hi, 32'd2);
    @(negedge clk);
`ifdef MULT_DIV_UNSIGNED_EN
    start_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'd2);
    wait_done(lat);
    chk("t7_hi", hi, 32'h1);
    chk("t7_lo", lo, 32'hFFFFFFFE);
`else
    start_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'd2);
    wait_done(lat);
    chk("t7_hi", hi, 32'hFFFFFFFF);
    chk("t7_lo", lo, 32'hFFFFFFFE);
`endif
    @(negedge clk);
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFE);
    wait_done(lat);
    chk("t8_lo", lo, 32'hFFFFFFFD);
    chk("t8_hi", hi, 32'd1);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
